xif_coproc_arbiter: RTL



---
 rtl/xif_coproc_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/xif_coproc_arbiter.sv
// Shares one CORE-V-XIF coprocessor between NUM_REQ CPU ports (issue/commit/result).
// One transaction in flight at a time, granted round-robin and owned until it completes.
module xif_coproc_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int X_ID_WIDTH = 4,
    parameter int X_NUM_RS   = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [NUM_REQ-1:0]               req_issue_valid_i,
    output logic [NUM_REQ-1:0]               req_issue_ready_o,
    input  logic [NUM_REQ*32-1:0]            req_issue_instr_i,
    input  logic [NUM_REQ*X_ID_WIDTH-1:0]    req_issue_id_i,
    input  logic [NUM_REQ*X_NUM_RS*32-1:0]   req_issue_rs_i,
    input  logic [NUM_REQ*X_NUM_RS-1:0]      req_issue_rs_valid_i,
    output logic [NUM_REQ-1:0]               req_issue_accept_o,
    output logic [NUM_REQ-1:0]               req_issue_writeback_o,

    input  logic [NUM_REQ-1:0]               req_commit_valid_i,
    input  logic [NUM_REQ-1:0]               req_commit_kill_i,
    input  logic [NUM_REQ*X_ID_WIDTH-1:0]    req_commit_id_i,

    output logic [NUM_REQ-1:0]               req_result_valid_o,
    input  logic [NUM_REQ-1:0]               req_result_ready_i,
    output logic [X_ID_WIDTH-1:0]            req_result_id_o,
    output logic [31:0]                      req_result_data_o,
    output logic [4:0]                       req_result_rd_o,
    output logic                             req_result_we_o,

    output logic                             cop_issue_valid_o,
    input  logic                             cop_issue_ready_i,
    output logic [31:0]                      cop_issue_instr_o,
    output logic [X_ID_WIDTH-1:0]            cop_issue_id_o,
    output logic [X_NUM_RS*32-1:0]           cop_issue_rs_o,
    output logic [X_NUM_RS-1:0]              cop_issue_rs_valid_o,
    input  logic                             cop_issue_accept_i,
    input  logic                             cop_issue_writeback_i,

    output logic                             cop_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]            cop_commit_id_o,
    output logic                             cop_commit_kill_o,

    input  logic                             cop_result_valid_i,
    output logic                             cop_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]            cop_result_id_i,
    input  logic [31:0]                      cop_result_data_i,
    input  logic [4:0]                       cop_result_rd_i,
    input  logic                             cop_result_we_i,

    output logic                             busy_o,
    output logic [$clog2(NUM_REQ)-1:0]       owner_o
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_COMMIT, WAIT_RESULT} state_t;

    state_t                  state_q, state_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic [OW-1:0]           prio_q, prio_d;
    logic [OW-1:0]           winner, cand, next_prio;
    logic                    found;
    logic                    wb_q, wb_d;
    logic [X_ID_WIDTH-1:0]   id_q;
    logic [X_ID_WIDTH-1:0]   owner_issue_id, owner_commit_id;
    logic                    issue_hs, commit_match, result_hs;

    // First valid requester at or after prio_q, scanning upward with wrap.
    always_comb begin
        found  = 1'b0;
        winner = prio_q;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = OW'((int'(prio_q) + i) % NUM_REQ);
            if (!found && req_issue_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign next_prio       = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_issue_id  = req_issue_id_i[owner_q*X_ID_WIDTH +: X_ID_WIDTH];
    assign owner_commit_id = req_commit_id_i[owner_q*X_ID_WIDTH +: X_ID_WIDTH];

    assign issue_hs     = (state_q == ISSUE) && cop_issue_ready_i;
    assign commit_match = (state_q == WAIT_COMMIT) && req_commit_valid_i[owner_q] &&
                          (owner_commit_id == id_q);
    assign result_hs    = (state_q == WAIT_RESULT) && cop_result_valid_i &&
                          req_result_ready_i[owner_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            prio_q  <= '0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            wb_q    <= wb_d;
        end
    end

    // The ID is only compared while a transaction is active, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (issue_hs) begin
            id_q <= owner_issue_id;
        end
    end

    always_comb begin
        state_d               = state_q;
        owner_d               = owner_q;
        prio_d                = prio_q;
        wb_d                  = wb_q;
        req_issue_ready_o     = '0;
        req_issue_accept_o    = '0;
        req_issue_writeback_o = '0;
        req_result_valid_o    = '0;
        cop_issue_valid_o     = 1'b0;
        cop_issue_instr_o     = '0;
        cop_issue_id_o        = '0;
        cop_issue_rs_o        = '0;
        cop_issue_rs_valid_o  = '0;
        cop_commit_valid_o    = 1'b0;
        cop_commit_id_o       = '0;
        cop_commit_kill_o     = 1'b0;
        cop_result_ready_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cop_issue_valid_o              = 1'b1;
                cop_issue_instr_o              = req_issue_instr_i[owner_q*32 +: 32];
                cop_issue_id_o                 = owner_issue_id;
                cop_issue_rs_o                 = req_issue_rs_i[owner_q*X_NUM_RS*32 +: X_NUM_RS*32];
                cop_issue_rs_valid_o           = req_issue_rs_valid_i[owner_q*X_NUM_RS +: X_NUM_RS];
                req_issue_ready_o[owner_q]     = cop_issue_ready_i;
                req_issue_accept_o[owner_q]    = cop_issue_accept_i;
                req_issue_writeback_o[owner_q] = cop_issue_writeback_i;
                if (issue_hs) begin
                    wb_d = cop_issue_writeback_i;
                    if (cop_issue_accept_i) begin
                        state_d = WAIT_COMMIT;
                    end else begin
                        state_d = IDLE;
                        prio_d  = next_prio;
                    end
                end
            end
            WAIT_COMMIT: begin
                cop_commit_valid_o = commit_match;
                cop_commit_id_o    = id_q;
                cop_commit_kill_o  = commit_match && req_commit_kill_i[owner_q];
                if (commit_match) begin
                    if (req_commit_kill_i[owner_q] || !wb_q) begin
                        state_d = IDLE;
                        prio_d  = next_prio;
                    end else begin
                        state_d = WAIT_RESULT;
                    end
                end
            end
            WAIT_RESULT: begin
                req_result_valid_o[owner_q] = cop_result_valid_i;
                cop_result_ready_o          = req_result_ready_i[owner_q];
                if (result_hs) begin
                    state_d = IDLE;
                    prio_d  = next_prio;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result payload is broadcast; only the owner ever sees valid.
    assign req_result_id_o   = cop_result_id_i;
    assign req_result_data_o = cop_result_data_i;
    assign req_result_rd_o   = cop_result_rd_i;
    assign req_result_we_o   = cop_result_we_i;

    assign busy_o  = (state_q != IDLE);
    assign owner_o = owner_q;

endmodule
